// File: rtl/dvi_timing_pkg.sv
// Shared raster timing defaults (640x480@60, 800x525 total) and the colour-bar table.
package dvi_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CNT_W_DEF    = 13;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int BAR_COUNT = 8;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [BAR_COUNT] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/dvi_bar_pattern.sv
// Eight vertical colour bars for bring-up; bar index stepped by a per-line pixel counter.
module dvi_bar_pattern
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             pix_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] h_cnt,
  input  logic             de,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b
);

  localparam int BAR_W = H_ACTIVE / BAR_COUNT;

  logic [CNT_W-1:0] px_q;
  logic [CNT_W-1:0] px_p0;
  logic [2:0]       idx_q;
  logic [2:0]       idx_p0;
  logic [23:0]      rgb_p0;

  // h==0 forces both counters back to the first bar, so a line always starts white
  always_comb begin
    px_p0  = (h_cnt == '0) ? '0 : px_q;
    idx_p0 = (h_cnt == '0) ? '0 : idx_q;
    rgb_p0 = de ? BAR_RGB[idx_p0] : 24'h000000;
  end

  // stage p0 -> p1: registered alongside de in the top
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      px_q      <= '0;
      idx_q     <= '0;
      {r, g, b} <= 24'h000000;
    end else if (en) begin
      if (px_p0 == CNT_W'(BAR_W - 1)) begin
        px_q  <= '0;
        idx_q <= idx_p0 + 3'd1;
      end else begin
        px_q  <= px_p0 + CNT_W'(1);
        idx_q <= idx_p0;
      end
      {r, g, b} <= rgb_p0;
    end
  end

endmodule

// File: rtl/dvi_video_timing_gen.sv
// Raster timing generator feeding the TMDS encoders (DE, C0=hsync, C1=vsync, x/y).
// Optional colour-bar source on r/g/b when TEST_PATTERN_EN is defined.
module dvi_video_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = CNT_W_DEF
) (
  input  logic             pix_clk,
  input  logic             rst,
  input  logic             en,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
`ifdef TEST_PATTERN_EN
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
`endif
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             de_p0;
  logic             hs_p0;
  logic             vs_p0;

  always_comb begin
    h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last = (v_cnt == CNT_W'(V_TOTAL - 1));
    de_p0  = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    hs_p0  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_START + H_SYNC));
    vs_p0  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_START + V_SYNC));
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // stage p0 -> p1: every output is a registered decode of the same counter state
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      de          <= de_p0;
      hsync       <= hs_p0 ? HS_POL : ~HS_POL;
      vsync       <= vs_p0 ? VS_POL : ~VS_POL;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef TEST_PATTERN_EN
  dvi_bar_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_bar_pattern (
    .pix_clk (pix_clk),
    .rst     (rst),
    .en      (en),
    .h_cnt   (h_cnt),
    .de      (de_p0),
    .r       (r),
    .g       (g),
    .b       (b)
  );
`endif

endmodule

// File: tb/tb_dvi_video_timing_gen.sv
// Scoreboard bench for dvi_video_timing_gen on a reduced 24x10 raster (16x6 active).
module tb_dvi_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BW = HA / 8;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [12:0] x;
    logic [12:0] y;
    logic [23:0] rgb;
  } exp_t;

  logic        pix_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        de, hsync, vsync, line_start, frame_start;
  logic [12:0] x, y;
  logic [23:0] rgb_act;
`ifdef TEST_PATTERN_EN
  logic [7:0]  r, g, b;
  assign rgb_act = {r, g, b};
`else
  assign rgb_act = 24'h000000;
`endif

  dvi_video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .en          (en),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
`ifdef TEST_PATTERN_EN
    .r           (r),
    .g           (g),
    .b           (b),
`endif
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 pix_clk = ~pix_clk;

  int   tests = 0;
  int   failed = 0;
  exp_t q[$];
  exp_t last;
  exp_t reset_exp;
  int   mh, mv;
  logic measure = 1'b0;
  int   n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_ls = 0;

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t exp_at(input int h, input int v);
    exp_t e;
    e.de = (h < HA) && (v < VA);
    e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.x  = 13'(h);
    e.y  = 13'(v);
`ifdef TEST_PATTERN_EN
    e.rgb = e.de ? bar_colour(h / BW) : 24'h000000;
`else
    e.rgb = 24'h000000;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; the expected output after the coming edge is queued.
  task automatic cyc(input logic e, input logic r_in);
    @(negedge pix_clk);
    en  = e;
    rst = r_in;
    if (r_in) begin
      mh = 0; mv = 0; last = reset_exp;
    end else if (e) begin
      last = exp_at(mh, mv);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    q.push_back(last);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " x"}, 32'(x), 32'd0);
    chk({tag, " y"}, 32'(y), 32'd0);
    chk({tag, " de"}, 32'(de), 32'd0);
    chk({tag, " hsync"}, 32'(hsync), 32'd1);
    chk({tag, " vsync"}, 32'(vsync), 32'd1);
    chk({tag, " line_start"}, 32'(line_start), 32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " rgb"}, 32'(rgb_act), 32'd0);
  endtask

  // Monitor: compares every clocked output against the oldest queued expectation.
  always @(posedge pix_clk) begin
    exp_t a, e;
    #1;
    a = '{de: de, hs: hsync, vs: vsync, ls: line_start, fs: frame_start,
          x: x, y: y, rgb: rgb_act};
    if (measure) begin
      if (de) n_de++;
      if (!hsync) n_hs++;
      if (!vsync) n_vs++;
      if (frame_start) n_fs++;
      if (line_start) n_ls++;
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL scoreboard t=%0t got de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b rgb=%h, expected de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b rgb=%h",
                 $time, a.de, a.hs, a.vs, a.x, a.y, a.ls, a.fs, a.rgb,
                 e.de, e.hs, e.vs, e.x, e.y, e.ls, e.fs, e.rgb);
      end
    end
  end

  initial begin
    reset_exp = '{de: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0,
                  x: 13'd0, y: 13'd0, rgb: 24'h000000};
    last = reset_exp;
    mh = 0; mv = 0;
    rst = 1'b0;
    en  = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_state("reset");

    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);

    // Two full frames with en held high
    measure = 1'b1;
    cyc(1'b1, 1'b0);
    @(posedge pix_clk); #2;
    chk("first x", 32'(x), 32'd0);
    chk("first y", 32'(y), 32'd0);
    chk("first de", 32'(de), 32'd1);
    chk("first frame_start", 32'(frame_start), 32'd1);
    for (int i = 1; i < 2 * HT * VT; i++) cyc(1'b1, 1'b0);
    @(posedge pix_clk); #2;
    measure = 1'b0;
    chk("de cycles/2 frames", 32'(n_de), 32'd192);
    chk("hsync low cycles/2 frames", 32'(n_hs), 32'd60);
    chk("vsync low cycles/2 frames", 32'(n_vs), 32'd96);
    chk("frame_start pulses/2 frames", 32'(n_fs), 32'd2);
    chk("line_start pulses/2 frames", 32'(n_ls), 32'd20);

    // Freeze at output x=5
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    @(posedge pix_clk); #2;
    chk("frozen x", 32'(x), 32'd5);
    chk("frozen de", 32'(de), 32'd1);
    chk("frozen hsync", 32'(hsync), 32'd1);
`ifdef TEST_PATTERN_EN
    chk("frozen rgb", 32'(rgb_act), 32'h00FFFF);
`endif
    cyc(1'b1, 1'b0);
    @(posedge pix_clk); #2;
    chk("resume x", 32'(x), 32'd6);
`ifdef TEST_PATTERN_EN
    chk("resume rgb", 32'(rgb_act), 32'h00FF00);
`endif

    // Run to output (10,3), then reset between clock edges
    for (int i = 0; i < 76; i++) cyc(1'b1, 1'b0);
    @(posedge pix_clk); #3;
    chk("pre-reset x", 32'(x), 32'd10);
    chk("pre-reset y", 32'(y), 32'd3);
    rst = 1'b1;
    mh = 0; mv = 0; last = reset_exp;
    #1 chk_reset_state("async reset");

    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < HT * VT; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc((i % 3) != 0, 1'b0);
    @(posedge pix_clk); #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
